// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the FIX tag-CAM controller.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } cam_ctrl_state_t;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_KEY_WIDTH  = 32;
    localparam int DEF_CAM_DEPTH  = 1 << DEF_ADDR_WIDTH;

    function automatic int cam_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: multi-hot vector to binary index plus an any flag.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [cam_depth(ADDR_WIDTH)-1:0] vec_i,
    output logic [ADDR_WIDTH-1:0]            idx_o,
    output logic                             any_o
);

    localparam int DEPTH = cam_depth(ADDR_WIDTH);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path infers a latch.
        idx_o = '0;
        any_o = 1'b0;
        // Scan downwards so the last assignment made is the lowest set index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ADDR_WIDTH'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Arbitration/sequencing controller for the FIX parser tag CAM (valid bitmap, free-slot allocator).
// Optional write duplicate check enabled by defining CAM_CTRL_DUP_CHECK_EN.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int KEY_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_req_i,
    input  logic [KEY_WIDTH-1:0]             wr_key_i,
    output logic                             wr_gnt_o,
    output logic                             wr_done_o,
    output logic [ADDR_WIDTH-1:0]            wr_addr_o,
    output logic                             wr_dup_o,
    output logic                             wr_full_o,
    input  logic                             lk_req_i,
    input  logic [KEY_WIDTH-1:0]             lk_key_i,
    output logic                             lk_gnt_o,
    output logic                             lk_valid_o,
    output logic                             lk_hit_o,
    output logic [ADDR_WIDTH-1:0]            lk_addr_o,
    input  logic                             clr_i,
    output logic [cam_depth(ADDR_WIDTH)-1:0] cam_we_o,
    output logic [KEY_WIDTH-1:0]             cam_wkey_o,
    output logic                             cam_search_o,
    output logic [KEY_WIDTH-1:0]             cam_skey_o,
    input  logic [cam_depth(ADDR_WIDTH)-1:0] cam_match_i
);

    localparam int CAM_DEPTH = cam_depth(ADDR_WIDTH);

    cam_ctrl_state_t         state_q, state_d;
    logic [CAM_DEPTH-1:0]    valid_q, valid_d;
    logic                    clr_pend_q, clr_pend_d;
    logic                    last_wr_q, last_wr_d;
    logic                    wr_gnt_q, wr_gnt_d;
    logic                    lk_gnt_q, lk_gnt_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                    wr_done_q, wr_done_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                    lk_valid_q, lk_valid_d;
    logic                    lk_hit_q, lk_hit_d;
    logic [ADDR_WIDTH-1:0]   lk_addr_q, lk_addr_d;
`ifdef CAM_CTRL_DUP_CHECK_EN
    logic                    op_wr_q, op_wr_d;
    logic                    wr_dup_q, wr_dup_d;
`endif

    logic [CAM_DEPTH-1:0]    match_masked;
    logic [ADDR_WIDTH-1:0]   match_idx;
    logic                    match_any;
    logic [ADDR_WIDTH-1:0]   free_idx;
    logic                    free_any;
    logic                    wr_elig;

    assign match_masked = cam_match_i & valid_q;

    cam_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_match_enc (
        .vec_i (match_masked),
        .idx_o (match_idx),
        .any_o (match_any)
    );

    cam_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_enc (
        .vec_i (~valid_q),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    // No free slot is exactly the AND of the valid bitmap.
    assign wr_full_o = ~free_any;
    assign wr_elig   = wr_req_i & free_any;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        clr_pend_d = clr_pend_q | clr_i;
        last_wr_d  = last_wr_q;
        wr_gnt_d   = 1'b0;
        lk_gnt_d   = 1'b0;
        key_d      = key_q;
        waddr_d    = waddr_q;
        wr_done_d  = 1'b0;
        wr_addr_d  = '0;
        lk_valid_d = 1'b0;
        lk_hit_d   = 1'b0;
        lk_addr_d  = '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
        op_wr_d    = op_wr_q;
        wr_dup_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // A grant issued last cycle commits this cycle; clears wait as pending.
                if (wr_gnt_q) begin
                    key_d   = wr_key_i;
                    waddr_d = free_idx;
`ifdef CAM_CTRL_DUP_CHECK_EN
                    op_wr_d = 1'b1;
                    state_d = SEARCH;
`else
                    state_d = WRITE;
`endif
                end else if (lk_gnt_q) begin
                    key_d   = lk_key_i;
`ifdef CAM_CTRL_DUP_CHECK_EN
                    op_wr_d = 1'b0;
`endif
                    state_d = SEARCH;
                end else if (clr_pend_q || clr_i) begin
                    valid_d    = '0;
                    clr_pend_d = 1'b0;
                end else if (lk_req_i && (last_wr_q || !wr_elig)) begin
                    lk_gnt_d  = 1'b1;
                    last_wr_d = 1'b0;
                end else if (wr_elig) begin
                    wr_gnt_d  = 1'b1;
                    last_wr_d = 1'b1;
                end
            end
            SEARCH: state_d = WAIT;
            WAIT: begin
                state_d = RESP;
`ifdef CAM_CTRL_DUP_CHECK_EN
                if (op_wr_q) begin
                    if (match_any) begin
                        wr_done_d = 1'b1;
                        wr_dup_d  = 1'b1;
                        wr_addr_d = match_idx;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    lk_valid_d = 1'b1;
                    lk_hit_d   = match_any;
                    lk_addr_d  = match_idx;
                end
`else
                lk_valid_d = 1'b1;
                lk_hit_d   = match_any;
                lk_addr_d  = match_idx;
`endif
            end
            WRITE: begin
                valid_d[waddr_q] = 1'b1;
                wr_done_d        = 1'b1;
                wr_addr_d        = waddr_q;
                state_d          = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            // NOTE: the valid bitmap is control state and must reset; the CAM key storage itself needs no reset.
            valid_q    <= '0;
            clr_pend_q <= 1'b0;
            last_wr_q  <= 1'b1;
            wr_gnt_q   <= 1'b0;
            lk_gnt_q   <= 1'b0;
            key_q      <= '0;
            waddr_q    <= '0;
            wr_done_q  <= 1'b0;
            wr_addr_q  <= '0;
            lk_valid_q <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_addr_q  <= '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
            op_wr_q    <= 1'b0;
            wr_dup_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q    <= state_d;
            valid_q    <= valid_d;
            clr_pend_q <= clr_pend_d;
            last_wr_q  <= last_wr_d;
            wr_gnt_q   <= wr_gnt_d;
            lk_gnt_q   <= lk_gnt_d;
            key_q      <= key_d;
            waddr_q    <= waddr_d;
            wr_done_q  <= wr_done_d;
            wr_addr_q  <= wr_addr_d;
            lk_valid_q <= lk_valid_d;
            lk_hit_q   <= lk_hit_d;
            lk_addr_q  <= lk_addr_d;
`ifdef CAM_CTRL_DUP_CHECK_EN
            op_wr_q    <= op_wr_d;
            wr_dup_q   <= wr_dup_d;
`endif
        end
    end

    assign wr_gnt_o     = wr_gnt_q;
    assign lk_gnt_o     = lk_gnt_q;
    assign wr_done_o    = wr_done_q;
    assign wr_addr_o    = wr_addr_q;
    assign lk_valid_o   = lk_valid_q;
    assign lk_hit_o     = lk_hit_q;
    assign lk_addr_o    = lk_addr_q;
`ifdef CAM_CTRL_DUP_CHECK_EN
    assign wr_dup_o     = wr_dup_q;
`else
    assign wr_dup_o     = 1'b0;
`endif

    // Address decoder output, qualified by the WRITE state.
    assign cam_we_o     = (state_q == WRITE) ? (CAM_DEPTH'(1) << waddr_q) : '0;
    assign cam_search_o = (state_q == SEARCH);
    assign cam_wkey_o   = key_q;
    assign cam_skey_o   = key_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: behavioural CAM array, result scoreboards, scenario tasks.
module tb_cam_ctrl;

    typedef struct packed {
        logic       dup;
        logic       hit;
        logic [4:0] addr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [31:0] wr_key;
    logic        wr_gnt_o, wr_done_o, wr_dup_o, wr_full_o;
    logic [4:0]  wr_addr_o;
    logic        lk_req;
    logic [31:0] lk_key;
    logic        lk_gnt_o, lk_valid_o, lk_hit_o;
    logic [4:0]  lk_addr_o;
    logic        clr;
    logic [31:0] cam_we_o;
    logic [31:0] cam_wkey_o;
    logic        cam_search_o;
    logic [31:0] cam_skey_o;
    logic [31:0] match_r;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    force_ones = 0;
    string grant_log;
    exp_t  wr_exp_q[$];
    exp_t  lk_exp_q[$];
    logic [31:0] cam_mem [32];

    cam_ctrl #(.ADDR_WIDTH(5), .KEY_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req_i     (wr_req),
        .wr_key_i     (wr_key),
        .wr_gnt_o     (wr_gnt_o),
        .wr_done_o    (wr_done_o),
        .wr_addr_o    (wr_addr_o),
        .wr_dup_o     (wr_dup_o),
        .wr_full_o    (wr_full_o),
        .lk_req_i     (lk_req),
        .lk_key_i     (lk_key),
        .lk_gnt_o     (lk_gnt_o),
        .lk_valid_o   (lk_valid_o),
        .lk_hit_o     (lk_hit_o),
        .lk_addr_o    (lk_addr_o),
        .clr_i        (clr),
        .cam_we_o     (cam_we_o),
        .cam_wkey_o   (cam_wkey_o),
        .cam_search_o (cam_search_o),
        .cam_skey_o   (cam_skey_o),
        .cam_match_i  (match_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CAM array: match vector appears the cycle after the search strobe.
    initial begin
        for (int i = 0; i < 32; i++) cam_mem[i] = 32'h0;
        match_r = 32'h0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (cam_we_o[i]) cam_mem[i] <= cam_wkey_o;
            if (cam_search_o) match_r[i] <= force_ones | (cam_mem[i] == cam_skey_o);
        end
    end

    // Result scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wr_done_o === 1'b1) begin
                n_checks++;
                if (wr_exp_q.size() == 0) begin
                    $display("FAIL wr_result: unexpected wr_done_o addr=%0d", wr_addr_o);
                    n_fail++;
                end else begin
                    e = wr_exp_q.pop_front();
                    if (wr_addr_o !== e.addr || wr_dup_o !== e.dup) begin
                        $display("FAIL wr_result: got addr=%0d dup=%b, expected addr=%0d dup=%b",
                                 wr_addr_o, wr_dup_o, e.addr, e.dup);
                        n_fail++;
                    end
                end
            end
            if (lk_valid_o === 1'b1) begin
                n_checks++;
                if (lk_exp_q.size() == 0) begin
                    $display("FAIL lk_result: unexpected lk_valid_o hit=%b", lk_hit_o);
                    n_fail++;
                end else begin
                    e = lk_exp_q.pop_front();
                    if (lk_hit_o !== e.hit || lk_addr_o !== e.addr) begin
                        $display("FAIL lk_result: got hit=%b addr=%0d, expected hit=%b addr=%0d",
                                 lk_hit_o, lk_addr_o, e.hit, e.addr);
                        n_fail++;
                    end
                end
            end
        end
    end

    task automatic wr_op(input logic [31:0] key, input logic [4:0] exp_addr, input bit exp_dup);
        exp_t        e;
        int          t, k, lat;
        bit          got;
        logic [31:0] exp_we;
`ifdef CAM_CTRL_DUP_CHECK_EN
        lat = exp_dup ? 3 : 4;
`else
        lat = 2;
`endif
        @(negedge clk);
        wr_req = 1'b1;
        wr_key = key;
        e.dup = exp_dup; e.hit = 1'b0; e.addr = exp_addr;
        wr_exp_q.push_back(e);
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (wr_gnt_o === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL wr_grant: key=%h no wr_gnt_o within 80 cycles", key);
            n_fail++;
            wr_req = 1'b0;
            void'(wr_exp_q.pop_back());
            return;
        end
        grant_log = {grant_log, "W"};
        t = cyc;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                wr_req = 1'b0;
                wr_key = $urandom;
            end
            k = cyc - t;
            exp_we = (!exp_dup && k == lat - 1) ? (32'd1 << exp_addr) : 32'd0;
            n_checks++;
            if (cam_we_o !== exp_we) begin
                $display("FAIL wr_cam_we: key=%h T+%0d got %h expected %h", key, k, cam_we_o, exp_we);
                n_fail++;
            end
            if (wr_done_o === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || (cyc - t) != lat) begin
            $display("FAIL wr_latency: key=%h got T+%0d (done=%b) expected T+%0d", key, cyc - t, got, lat);
            n_fail++;
        end
    endtask

    task automatic lk_op(input logic [31:0] key, input bit exp_hit, input logic [4:0] exp_addr);
        exp_t e;
        int   t, k;
        bit   got;
        @(negedge clk);
        lk_req = 1'b1;
        lk_key = key;
        e.dup = 1'b0; e.hit = exp_hit; e.addr = exp_addr;
        lk_exp_q.push_back(e);
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (lk_gnt_o === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL lk_grant: key=%h no lk_gnt_o within 80 cycles", key);
            n_fail++;
            lk_req = 1'b0;
            void'(lk_exp_q.pop_back());
            return;
        end
        grant_log = {grant_log, "L"};
        t = cyc;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                lk_req = 1'b0;
                lk_key = $urandom;
            end
            k = cyc - t;
            n_checks++;
            if (cam_search_o !== (k == 1)) begin
                $display("FAIL lk_search: key=%h T+%0d got %b expected %b", key, k, cam_search_o, (k == 1));
                n_fail++;
            end
            if (lk_valid_o === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || (cyc - t) != 3) begin
            $display("FAIL lk_latency: key=%h got T+%0d (valid=%b) expected T+3", key, cyc - t, got);
            n_fail++;
        end
    endtask

    task automatic clr_op();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_full_o !== 1'b0) begin
            $display("FAIL clr_full: wr_full_o got %b expected 0", wr_full_o);
            n_fail++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if ({wr_gnt_o, wr_done_o, wr_addr_o, wr_dup_o, wr_full_o, lk_gnt_o, lk_valid_o, lk_hit_o,
             lk_addr_o, cam_search_o} !== '0 || cam_we_o !== 32'h0 ||
            cam_wkey_o !== 32'h0 || cam_skey_o !== 32'h0) begin
            $display("FAIL %s: outputs not zero gnt=%b done=%b full=%b lkv=%b we=%h wkey=%h skey=%h srch=%b",
                     tag, wr_gnt_o, wr_done_o, wr_full_o, lk_valid_o, cam_we_o, cam_wkey_o,
                     cam_skey_o, cam_search_o);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_active");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_write_lookup();
        wr_op(32'h0000_0035, 5'd0, 1'b0);
        lk_op(32'h0000_0035, 1'b1, 5'd0);
    endtask

    task automatic test_valid_mask();
        clr_op();
        force_ones = 1'b1;
        lk_op(32'h0000_0099, 1'b0, 5'd0);
        force_ones = 1'b0;
        lk_op(32'h0000_0035, 1'b0, 5'd0);
    endtask

    task automatic test_fill();
        bit blocked;
        for (int i = 0; i < 32; i++) wr_op(32'h100 + i, 5'(i), 1'b0);
        @(negedge clk);
        n_checks++;
        if (wr_full_o !== 1'b1) begin
            $display("FAIL fill_full: wr_full_o got %b expected 1", wr_full_o);
            n_fail++;
        end
        force_ones = 1'b1;
        lk_op(32'h0000_0777, 1'b1, 5'd0);
        force_ones = 1'b0;
        blocked = 1'b0;
        fork
            begin
                @(negedge clk);
                wr_req = 1'b1;
                wr_key = 32'h0000_0999;
                repeat (20) begin
                    @(negedge clk);
                    if (wr_gnt_o === 1'b1) blocked = 1'b1;
                end
                wr_req = 1'b0;
            end
            lk_op(32'h0000_0105, 1'b1, 5'd5);
        join
        n_checks++;
        if (blocked) begin
            $display("FAIL full_block: wr_gnt_o got 1 while full, expected 0");
            n_fail++;
        end
        clr_op();
        wr_op(32'h0000_0abc, 5'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        clr_op();
        grant_log = "";
        fork
            begin
                lk_op(32'h0000_0011, 1'b0, 5'd0);
                lk_op(32'h0000_0011, 1'b1, 5'd0);
            end
            begin
                wr_op(32'h0000_0011, 5'd0, 1'b0);
                wr_op(32'h0000_0022, 5'd1, 1'b0);
            end
        join
        n_checks++;
        if (grant_log != "LWLW") begin
            $display("FAIL alternation: grant order got %s expected LWLW", grant_log);
            n_fail++;
        end
    endtask

    task automatic test_clear_during_op();
        fork
            lk_op(32'h0000_0022, 1'b1, 5'd1);
            begin
                for (int i = 0; i < 40 && lk_gnt_o !== 1'b1; i++) @(negedge clk);
                repeat (2) @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        lk_op(32'h0000_0022, 1'b0, 5'd0);
    endtask

    task automatic test_reset_mid_write();
        bit got;
        @(negedge clk);
        wr_req = 1'b1;
        wr_key = 32'h0000_0077;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wr_gnt_o === 1'b1) got = 1;
        end
        @(negedge clk);
        wr_req = 1'b0;
        for (int i = 0; i < 8 && cam_we_o === 32'h0; i++) @(negedge clk);
        n_checks++;
        if (!got || cam_we_o !== 32'h1) begin
            $display("FAIL rst_setup: grant=%b cam_we_o got %h expected 00000001", got, cam_we_o);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_write");
        @(negedge clk);
        rst_n = 1'b1;
        lk_op(32'h0000_0077, 1'b0, 5'd0);
        wr_op(32'h0000_0078, 5'd0, 1'b0);
    endtask

`ifdef CAM_CTRL_DUP_CHECK_EN
    task automatic test_dup();
        wr_op(32'h0000_0078, 5'd0, 1'b1);
        wr_op(32'h0000_0079, 5'd1, 1'b0);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        wr_req = 1'b0;
        wr_key = 32'h0;
        lk_req = 1'b0;
        lk_key = 32'h0;
        clr    = 1'b0;
        grant_log = "";
        test_reset();
        test_write_lookup();
        test_valid_mask();
        test_fill();
        test_back_to_back();
        test_clear_during_op();
        test_reset_mid_write();
`ifdef CAM_CTRL_DUP_CHECK_EN
        test_dup();
`endif
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr_exp_q.size() != 0 || lk_exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: pending wr=%0d lk=%0d expected 0", wr_exp_q.size(), lk_exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
